// File: rtl/traffic_lights_cmd_sched_if.sv
// Request/command bundle between requesters, the command scheduler and the traffic_lights cmd bus.
interface traffic_lights_cmd_sched_if #(
    parameter int DATA_W = 16
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][1:0]        req_op;
    logic [1:0][DATA_W-1:0] req_red;
    logic [1:0][DATA_W-1:0] req_yellow;
    logic [1:0][DATA_W-1:0] req_green;
    logic [2:0]             cmd_type;
    logic [DATA_W-1:0]      cmd_data;
    logic                   cmd_valid;

    modport master (
        output req_valid, req_op, req_red, req_yellow, req_green,
        input  req_ready, cmd_type, cmd_data, cmd_valid
    );

    modport slave (
        input  req_valid, req_op, req_red, req_yellow, req_green,
        output req_ready, cmd_type, cmd_data, cmd_valid
    );
endinterface

// File: rtl/traffic_lights_cmd_sched.sv
// Two-requester round-robin scheduler that expands a configuration request into
// a paced sequence of single-cycle traffic_lights commands.
module traffic_lights_cmd_sched #(
    parameter int CMD_GAP = 1,
    parameter int DATA_W  = 16
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    traffic_lights_cmd_sched_if.slave bus,
    output logic                      busy_o,
    output logic                      grant_o,
    output logic                      done_o,
    output logic                      err_o
);
    localparam int               GAP_W    = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (CMD_GAP > 0) ? GAP_W'(CMD_GAP - 1) : '0;

    localparam logic [1:0] OP_PROGRAM = 2'd0;
    localparam logic [1:0] OP_OFF     = 2'd1;
    localparam logic [1:0] OP_SERVICE = 2'd2;

    localparam logic [2:0] CMD_ON      = 3'd0;
    localparam logic [2:0] CMD_OFF     = 3'd1;
    localparam logic [2:0] CMD_SERVICE = 3'd2;
    localparam logic [2:0] CMD_GREEN   = 3'd3;
    localparam logic [2:0] CMD_RED     = 3'd4;
    localparam logic [2:0] CMD_YELLOW  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_SVC, S_RED, S_YEL, S_GRN, S_ON, S_OFF, S_GAP
    } state_t;

    state_t            state;
    state_t            resume;
    state_t            target;
    logic [GAP_W-1:0]  gap_cnt;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] red_q;
    logic [DATA_W-1:0] yel_q;
    logic [DATA_W-1:0] grn_q;
    logic              last_grant;
    logic              pick;
    logic              accept;
    logic [1:0]        ready;
    logic [1:0]        in_op;
    logic              cmd_valid_q;
    logic [2:0]        cmd_type_q;
    logic [DATA_W-1:0] cmd_data_q;

    // Which command follows 'cur'; zero time fields are skipped outright.
    function automatic state_t next_step(input state_t cur, input logic [1:0] op,
                                         input logic red_nz, input logic yel_nz,
                                         input logic grn_nz);
        state_t nxt;
        nxt = S_IDLE;
        case (cur)
            S_IDLE: begin
                if (op == OP_PROGRAM || op == OP_SERVICE) nxt = S_SVC;
                else if (op == OP_OFF)                    nxt = S_OFF;
            end
            S_SVC: begin
                if (op == OP_PROGRAM)
                    nxt = red_nz ? S_RED : (yel_nz ? S_YEL : (grn_nz ? S_GRN : S_ON));
            end
            S_RED:   nxt = yel_nz ? S_YEL : (grn_nz ? S_GRN : S_ON);
            S_YEL:   nxt = grn_nz ? S_GRN : S_ON;
            S_GRN:   nxt = S_ON;
            default: nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

    function automatic logic [2:0] cmd_type_of(input state_t s);
        logic [2:0] t;
        case (s)
            S_SVC:   t = CMD_SERVICE;
            S_RED:   t = CMD_RED;
            S_YEL:   t = CMD_YELLOW;
            S_GRN:   t = CMD_GREEN;
            S_OFF:   t = CMD_OFF;
            default: t = CMD_ON;
        endcase
        return t;
    endfunction

    function automatic logic [DATA_W-1:0] cmd_data_of(input state_t s,
                                                      input logic [DATA_W-1:0] r,
                                                      input logic [DATA_W-1:0] y,
                                                      input logic [DATA_W-1:0] g);
        logic [DATA_W-1:0] d;
        case (s)
            S_RED:   d = r;
            S_YEL:   d = y;
            S_GRN:   d = g;
            default: d = '0;
        endcase
        return d;
    endfunction

    // Arbitration plus the next command to issue. From IDLE the first command
    // never carries a time, so the latched fields are safe to use everywhere.
    always_comb begin
        pick  = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
        ready = 2'b00;
        if (state == S_IDLE && (|bus.req_valid) && !arst_i)
            ready[pick] = 1'b1;
        accept = |(ready & bus.req_valid);
        in_op  = bus.req_op[pick];
        if (state == S_IDLE)
            target = next_step(S_IDLE, in_op, 1'b0, 1'b0, 1'b0);
        else if (state == S_GAP)
            target = resume;
        else
            target = next_step(state, op_q, |red_q, |yel_q, |grn_q);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= S_IDLE;
            resume      <= S_IDLE;
            gap_cnt     <= '0;
            op_q        <= '0;
            red_q       <= '0;
            yel_q       <= '0;
            grn_q       <= '0;
            last_grant  <= 1'b1;
            grant_o     <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= '0;
            cmd_data_q  <= '0;
        end else begin
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= '0;
            cmd_data_q  <= '0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= in_op;
                        red_q      <= bus.req_red[pick];
                        yel_q      <= bus.req_yellow[pick];
                        grn_q      <= bus.req_green[pick];
                        grant_o    <= pick;
                        last_grant <= pick;
                        if (target == S_IDLE) begin
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else begin
                            state       <= target;
                            cmd_valid_q <= 1'b1;
                            cmd_type_q  <= cmd_type_of(target);
                            cmd_data_q  <= cmd_data_of(target, red_q, yel_q, grn_q);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (target == S_IDLE) begin
                        state  <= S_IDLE;
                        done_o <= 1'b1;
                    end else begin
                        state       <= target;
                        cmd_valid_q <= 1'b1;
                        cmd_type_q  <= cmd_type_of(target);
                        cmd_data_q  <= cmd_data_of(target, red_q, yel_q, grn_q);
                    end
                end
                default: begin
                    // A command was just presented: pace it, or chain straight on when there is no gap.
                    if (CMD_GAP > 0) begin
                        state   <= S_GAP;
                        resume  <= target;
                        gap_cnt <= GAP_LOAD;
                    end else if (target == S_IDLE) begin
                        state  <= S_IDLE;
                        done_o <= 1'b1;
                    end else begin
                        state       <= target;
                        cmd_valid_q <= 1'b1;
                        cmd_type_q  <= cmd_type_of(target);
                        cmd_data_q  <= cmd_data_of(target, red_q, yel_q, grn_q);
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_type  = cmd_type_q;
    assign bus.cmd_data  = cmd_data_q;
    assign busy_o        = (state != S_IDLE);
endmodule

// File: doc/traffic_lights_cmd_sched.md
Name: traffic_lights_cmd_sched

Overview:
- Two-requester command scheduler in front of one traffic_lights instance.
- Each requester (local operator panel, remote controller) submits a configuration request.
- The block arbitrates round-robin and expands the winning request into a paced series of single-cycle commands on the traffic_lights cmd bus (cmd_type/cmd_valid/cmd_data).
- Owns the order of mode and time programming so that no requester can write times while the light is running.

Parameters:
- CMD_GAP, 1, idle cycles inserted after every issued command (0 = back-to-back commands).
- DATA_W, 16, width of time fields and of cmd_data_o.

Ports:
- clk_i  in  1  single clock.
- arst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  2  per-requester request valid.
- req_ready_o  out  2  per-requester accept; at most one bit high.
- req_op_i  in  2x2  op per requester: 0=PROGRAM, 1=OFF, 2=SERVICE, 3=reserved.
- req_red_i  in  2xDATA_W  red time; 0 = leave unchanged.
- req_yellow_i  in  2xDATA_W  yellow time; 0 = leave unchanged.
- req_green_i  in  2xDATA_W  green time; 0 = leave unchanged.
- cmd_type_o  out  3  to traffic_lights: 0 on, 1 off, 2 service, 3 green time, 4 red time, 5 yellow time.
- cmd_data_o  out  DATA_W  command payload.
- cmd_valid_o  out  1  one-cycle command strobe.
- busy_o  out  1  high whenever state != IDLE.
- grant_o  out  1  index of the requester being served; holds its value after completion.
- done_o  out  1  one-cycle pulse when a request finishes.
- err_o  out  1  valid with done_o; high if the op was reserved.

Behaviour:
- Reset values (asynchronous, immediate):
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer last_grant=1, so requester 0 wins first.
  - An in-flight sequence is abandoned; no partial command is completed after reset is released.
- Arbitration (IDLE only, combinational):
  - Exactly one req_valid_i bit set: that requester is chosen.
  - Both set: the requester != last_grant is chosen.
  - req_ready_o[chosen] is high in that cycle. Handshake = valid & ready at the clock edge.
  - On accept: op and the three times are latched, grant_o and last_grant are updated, and the state leaves IDLE.
  - req_ready_o is 0 in all non-IDLE states. Requesters must hold valid and payload stable until ready.
- Command list per op, issued in this order:
  - PROGRAM: 2 (data 0), then 4 (red) if red!=0, then 5 (yellow) if yellow!=0, then 3 (green) if green!=0, then 0 (data 0). Zero-valued fields are skipped without consuming a slot.
  - OFF: 1 (data 0).
  - SERVICE: 2 (data 0).
  - reserved: no commands; done_o and err_o pulse on the cycle after accept.
- FSM states: IDLE -> SVC -> RED -> YEL -> GRN -> ON -> GAP -> IDLE. OFF uses an OFF state -> GAP. Skipped states are bypassed in the same transition.
- Timing:
  - Command n (0-based) has cmd_valid_o high exactly one cycle, at accept_edge+1+n*(CMD_GAP+1).
  - cmd_type_o/cmd_data_o are registered and valid only while cmd_valid_o=1; otherwise cmd_data_o=0.
  - After the last command there are CMD_GAP gap cycles.
  - The next cycle returns to IDLE: done_o=1 and busy_o=0 in that same cycle, and req_ready_o may already be high in it.
- Gap counter is $clog2(CMD_GAP+1) bits wide and reloads on each command. CMD_GAP=0 skips the GAP state entirely.
- Payload is latched, so requester changes after accept have no effect on the sequence in flight.
- Time fields pass through unmodified (full DATA_W; no clamping, no arithmetic).

Test Plan:
- Reset, then requester 0 PROGRAM red=5 yellow=3 green=7, CMD_GAP=1, accept at cycle T -> cmd_valid_o at T+1,3,5,7,9 with (type,data) = (2,0),(4,5),(5,3),(3,7),(0,0); done_o at T+11; err_o=0; busy_o high T+1..T+10.
- Both requesters valid in the same IDLE cycle (0: OFF, 1: SERVICE) -> requester 0 served first (cmd 1), then requester 1 (cmd 2) in the IDLE cycle after done; grant_o 0 then 1. Repeat with both valid -> order 0,1 alternates fairly.
- PROGRAM red=0 yellow=4 green=0 -> exactly three commands (2,0),(5,4),(0,0) at T+1,3,5; done_o at T+7.
- Reserved op=3 -> no cmd_valid_o; done_o=1 and err_o=1 at T+1; ready high again at T+1.
- arst_i asserted mid-PROGRAM, between the red and yellow commands -> all outputs 0 immediately, no further commands. After release, a new requester-0 request restarts at the SVC command.
- CMD_GAP=0: PROGRAM with all times nonzero -> five consecutive cmd_valid_o cycles T+1..T+5; done_o at T+6.
